ring_nic: RTL and testbench

- Parametrised network interface controller between the processor's NIC port and one ring router port.
- Decouples the two sides with two FIFOs:
  - an output FIFO (CPU → ring);
  - an input FIFO (ring → CPU).
- The CPU sees four memory-mapped locations, selected by `nicAddr`.
- Successor to the fixed one-entry NIC buffers: depth and width are parameters, and a sticky overflow flag and occupancy reporting are added.

---
 rtl/ring_nic.sv | 132 +++++++++++++
 tb/tb_ring_nic.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_nic.sv
// Ring network interface: CPU-facing register window over an output FIFO (CPU->ring)
// and an input FIFO (ring->CPU), with occupancy reporting and a sticky overflow flag.
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic [1:0]            nicAddr,
  input  logic [DATA_WIDTH-1:0] nicDataIn,
  output logic [DATA_WIDTH-1:0] nicDataOut,
  output logic                  netSo,
  input  logic                  netRo,
  output logic [DATA_WIDTH-1:0] netDo,
  input  logic                  netSi,
  output logic                  netRi,
  input  logic [DATA_WIDTH-1:0] netDi
);

  localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] omem_q [DEPTH];
  logic [DATA_WIDTH-1:0] imem_q [DEPTH];
  logic [PTR_W-1:0]      owr_q, owr_d, ord_q, ord_d;
  logic [PTR_W-1:0]      iwr_q, iwr_d, ird_q, ird_d;
  logic [CNT_W-1:0]      ocnt_q, ocnt_d, icnt_q, icnt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] stat_in, stat_out;

  logic cpu_rd, cpu_wr, ofull, ifull;
  logic o_push, o_pop, i_push, i_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                  input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return c + CNT_W'(1);
      2'b01:   return c - CNT_W'(1);
      default: return c;
    endcase
  endfunction

  assign cpu_rd = nicEn & ~nicWrEn;
  assign cpu_wr = nicEn & nicWrEn;
  assign ofull  = (ocnt_q == FULL);
  assign ifull  = (icnt_q == FULL);

  assign netSo  = (ocnt_q != '0);
  assign netDo  = netSo ? omem_q[ord_q] : '0;
  // Ready is forced low for the whole time reset is held, not just after the first edge.
  assign netRi  = ~ifull & ~reset;

  assign o_push = cpu_wr & (nicAddr == 2'b10) & ~ofull;
  assign o_pop  = netSo & netRo;
  assign i_push = netSi & netRi;
  assign i_pop  = cpu_rd & (nicAddr == 2'b00) & (icnt_q != '0);

  always_comb begin
    stat_in              = '0;
    stat_in[CNT_W:1]     = icnt_q;
    stat_in[0]           = (icnt_q != '0);
    stat_out             = '0;
    stat_out[CNT_W+1:2]  = ocnt_q;
    stat_out[1]          = ovf_q;
    stat_out[0]          = ofull;
  end

  always_comb begin
    owr_d   = o_push ? bump(owr_q) : owr_q;
    ord_d   = o_pop  ? bump(ord_q) : ord_q;
    iwr_d   = i_push ? bump(iwr_q) : iwr_q;
    ird_d   = i_pop  ? bump(ird_q) : ird_q;
    ocnt_d  = count_next(ocnt_q, o_push, o_pop);
    icnt_d  = count_next(icnt_q, i_push, i_pop);

    ovf_d = ovf_q;
    if (cpu_wr && nicAddr == 2'b10 && ofull)
      ovf_d = 1'b1;
    else if (cpu_wr && nicAddr == 2'b11)
      ovf_d = 1'b0;

    rdata_d = rdata_q;
    if (cpu_rd) begin
      case (nicAddr)
        2'b00:   rdata_d = (icnt_q != '0) ? imem_q[ird_q] : '0;
        2'b01:   rdata_d = stat_in;
        2'b10:   rdata_d = '0;
        default: rdata_d = stat_out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owr_q   <= '0;
      ord_q   <= '0;
      iwr_q   <= '0;
      ird_q   <= '0;
      ocnt_q  <= '0;
      icnt_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      owr_q   <= owr_d;
      ord_q   <= ord_d;
      iwr_q   <= iwr_d;
      ird_q   <= ird_d;
      ocnt_q  <= ocnt_d;
      icnt_q  <= icnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (o_push) omem_q[owr_q] <= nicDataIn;
    if (i_push) imem_q[iwr_q] <= netDi;
  end

  assign nicDataOut = rdata_q;

endmodule

// File: tb/tb_ring_nic.sv
// Scoreboard bench for ring_nic: queue-based FIFO model drives expectations,
// a separate monitor checks ring output, handshake flags and CPU read data.
module tb_ring_nic;

  localparam int DW    = 32;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          nicEn, nicWrEn;
  logic [1:0]    nicAddr;
  logic [DW-1:0] nicDataIn, nicDataOut;
  logic          netSo, netRo, netSi, netRi;
  logic [DW-1:0] netDo, netDi;

  ring_nic #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .nicAddr(nicAddr),
    .nicDataIn(nicDataIn), .nicDataOut(nicDataOut),
    .netSo(netSo), .netRo(netRo), .netDo(netDo),
    .netSi(netSi), .netRi(netRi), .netDi(netDi)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] out_m[$];
  logic [DW-1:0] in_m[$];
  logic [DW-1:0] rd_exp[$];
  logic          ovf_m  = 1'b0;
  logic          exp_so = 1'b0;
  logic          exp_ri = 1'b0;
  logic          mon_en = 1'b0;
  logic          rd_due = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Called at a negedge: drive one cycle of stimulus, advance the model, wait for next negedge.
  task automatic cyc(input logic en, input logic wr, input logic [1:0] a, input logic [DW-1:0] d,
                     input logic si, input logic [DW-1:0] di, input logic ro);
    logic [DW-1:0] v;
    nicEn = en; nicWrEn = wr; nicAddr = a; nicDataIn = d;
    netSi = si; netDi = di; netRo = ro;
    exp_so = (out_m.size() != 0);
    exp_ri = (in_m.size() < DEPTH);
    if (en && !wr) begin
      case (a)
        2'd0: v = (in_m.size() != 0) ? in_m.pop_front() : '0;
        2'd1: begin v = DW'(in_m.size()) << 1; v[0] = (in_m.size() != 0); end
        2'd2: v = '0;
        default: begin
          v = DW'(out_m.size()) << 2;
          v[1] = ovf_m;
          v[0] = (out_m.size() == DEPTH);
        end
      endcase
      rd_exp.push_back(v);
    end
    if (si && exp_ri) in_m.push_back(di);
    if (en && wr && a == 2'd2) begin
      if (out_m.size() == DEPTH) ovf_m = 1'b1;
      else out_m.push_back(d);
    end
    if (en && wr && a == 2'd3) ovf_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input logic ro);
    cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro);
  endtask

  task automatic rd(input logic [1:0] a, input logic ro);
    cyc(1'b1, 1'b0, a, '0, 1'b0, '0, ro);
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d, input logic ro);
    cyc(1'b1, 1'b1, a, d, 1'b0, '0, ro);
  endtask

  // Monitor: samples two time units before each rising edge.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      if (rd_due) begin
        if (rd_exp.size() == 0) fail_now("rd_unexpected");
        else chk("rd_data", nicDataOut, rd_exp.pop_front());
      end
      rd_due = nicEn & ~nicWrEn;
      chk("netSo", DW'(netSo), DW'(exp_so));
      chk("netRi", DW'(netRi), DW'(exp_ri));
      if (netSo && netRo) begin
        if (out_m.size() == 0) fail_now("ring_unexpected");
        else chk("ring_data", netDo, out_m.pop_front());
      end else if (!netSo) begin
        chk("netDo_idle", netDo, '0);
      end
    end
  end

  initial begin
    int w;
    int r;
    reset = 1'b1;
    nicEn = 0; nicWrEn = 0; nicAddr = 0; nicDataIn = 0;
    netSi = 0; netDi = 0; netRo = 0;
    #1;
    chk("rst_netSo", DW'(netSo), '0);
    chk("rst_netRi", DW'(netRi), '0);
    chk("rst_netDo", netDo, '0);
    chk("rst_dout", nicDataOut, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_netRi", DW'(netRi), DW'(1));
    exp_ri = 1'b1;
    mon_en = 1'b1;

    // CPU -> ring, fill without draining, then overflow and clear.
    wr(2'd2, 32'hA5, 1'b0);
    wr(2'd2, 32'h5A, 1'b0);
    rd(2'd3, 1'b0);
    for (int k = 2; k < DEPTH; k++) wr(2'd2, 32'h3C + k, 1'b0);
    rd(2'd3, 1'b0);
    wr(2'd2, 32'hFF, 1'b0);
    rd(2'd3, 1'b0);
    wr(2'd3, 32'h0, 1'b0);
    rd(2'd3, 1'b0);
    // Full FIFO, CPU write and router pop together: write dropped, overflow set.
    wr(2'd2, 32'hEE, 1'b1);
    rd(2'd3, 1'b0);
    repeat (DEPTH + 1) idle(1'b1);
    // One entry: push and pop in the same cycle keep occupancy at 1.
    wr(2'd2, 32'h11, 1'b0);
    wr(2'd2, 32'h22, 1'b1);
    rd(2'd3, 1'b0);
    wr(2'd3, 32'h0, 1'b1);
    repeat (2) idle(1'b1);

    // Empty read returns 0, ignored writes, read of 10.
    rd(2'd0, 1'b0);
    rd(2'd1, 1'b0);
    wr(2'd0, 32'h77, 1'b0);
    wr(2'd1, 32'h88, 1'b0);
    rd(2'd2, 1'b0);
    rd(2'd1, 1'b0);

    // Ring -> CPU: fill until not ready, then read while holding the extra word.
    w = 1;
    for (int k = 0; k < 20 && w <= DEPTH; k++) begin
      logic acc = (in_m.size() < DEPTH);
      cyc(1'b0, 1'b0, 2'd0, '0, 1'b1, DW'(w), 1'b0);
      if (acc) w++;
    end
    rd(2'd1, 1'b0);
    for (int k = 0; k < 20 && w <= DEPTH + 1; k++) begin
      logic acc = (in_m.size() < DEPTH);
      cyc(1'b1, 1'b0, 2'd0, '0, 1'b1, DW'(w), 1'b0);
      if (acc) w++;
    end
    repeat (DEPTH + 1) rd(2'd0, 1'b0);
    // Empty FIFO: router push and CPU pop together return 0, word remains.
    cyc(1'b1, 1'b0, 2'd0, '0, 1'b1, 32'hCAFE, 1'b0);
    rd(2'd1, 1'b0);
    rd(2'd0, 1'b0);

    // Randomised traffic through both directions.
    for (int k = 0; k < 600; k++) begin
      logic si = 1'(($urandom_range(0, 1)));
      logic ro = 1'(($urandom_range(0, 1)));
      logic [DW-1:0] d  = $urandom;
      logic [DW-1:0] di = $urandom;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: cyc(1'b1, 1'b1, 2'd2, d, si, di, ro);
        3, 4:    cyc(1'b1, 1'b0, 2'd0, '0, si, di, ro);
        5:       cyc(1'b1, 1'b0, 2'd1, '0, si, di, ro);
        6:       cyc(1'b1, 1'b0, 2'd3, '0, si, di, ro);
        7:       cyc(1'b1, 1'b1, 2'd3, d, si, di, ro);
        8:       cyc(1'b1, 1'b1, 2'(r[0]), d, si, di, ro);
        default: cyc(1'b1, 1'b0, 2'd2, '0, si, di, ro);
      endcase
    end
    for (int k = 0; k < DEPTH + 2; k++) rd(2'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("drain_out", DW'(out_m.size()), '0);
    chk("drain_rd", DW'(rd_exp.size()), '0);

    // Asynchronous reset mid-transfer with two words queued.
    wr(2'd2, 32'h1234, 1'b0);
    wr(2'd2, 32'h5678, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, '0, 1'b1, 32'h99, 1'b0);
    rd(2'd3, 1'b0);
    idle(1'b0);
    mon_en = 1'b0;
    netRo = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_netSo", DW'(netSo), '0);
    chk("arst_netRi", DW'(netRi), '0);
    chk("arst_netDo", netDo, '0);
    chk("arst_dout", nicDataOut, '0);
    out_m.delete();
    in_m.delete();
    rd_exp.delete();
    ovf_m = 1'b0;
    rd_due = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arel_netRi", DW'(netRi), DW'(1));
    exp_so = 1'b0;
    exp_ri = 1'b1;
    mon_en = 1'b1;
    rd(2'd3, 1'b0);
    rd(2'd1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("end_rd", DW'(rd_exp.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
